cbus_arbiter: RTL and testbench
===============================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of cache-bus requesters, legal range 2..4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ireqs, input, cbus_req_t[NREQ]: upstream requests (icache, dcache, ...), index 0 first.
REQ-005 SHALL have port iresps, output, cbus_resp_t[NREQ]: per-requester responses.
REQ-006 SHALL have port oreq, output, cbus_req_t: request to the shared memory-side cache bus.
REQ-007 SHALL have port oresp, input, cbus_resp_t: response from the shared bus.
REQ-008 SHALL have port grant, output, NREQ bits: one-hot current owner, all-zero when idle.

Function
REQ-009 SHALL implement FSM states ARB_IDLE and ARB_BUSY, plus registers owner (index) and rr_ptr (last-served index).
REQ-010 In ARB_IDLE with at least one ireqs[i].valid, the FSM SHALL select the first valid index searching rr_ptr+1, rr_ptr+2, ... modulo NREQ, latch it as owner, and move to ARB_BUSY at the next edge.
REQ-011 In ARB_IDLE with no valid request, the FSM SHALL stay in ARB_IDLE.
REQ-012 oreq SHALL equal ireqs[owner] in ARB_BUSY and SHALL be all-zero (valid=0) in ARB_IDLE; latency from request to oreq.valid is exactly 1 cycle.
REQ-013 Ownership SHALL be locked for the whole burst; other requests are ignored until release.
REQ-014 Release SHALL occur at the edge where, in ARB_BUSY, oresp.ready=1 and oresp.last=1: next state ARB_IDLE, rr_ptr<=owner.
REQ-015 After every release the bus SHALL be idle for exactly one cycle before the next grant; this bubble absorbs the finishing requester's valid deassertion.
REQ-016 If ireqs[owner].valid drops while in ARB_BUSY without last, the FSM SHALL return to ARB_IDLE at the next edge with rr_ptr<=owner; oreq.valid is 0 in that cycle by REQ-012.
REQ-017 iresps[i].data SHALL equal oresp.data for all i; iresps[i].ready and .last SHALL equal oresp.ready and .last only when state=ARB_BUSY and i=owner, else 0.
REQ-018 Response paths SHALL be combinational (zero latency); request path SHALL be driven from registered state plus combinational mux of ireqs.
REQ-019 Read and write bursts SHALL be treated identically (is_write, len, burst, strobe passed through unmodified).
REQ-020 An oresp.ready in ARB_IDLE SHALL be ignored and not forwarded.
REQ-021 grant SHALL equal one-hot(owner) in ARB_BUSY, else 0.

Reset
REQ-022 On resetn=0, asynchronously: state<=ARB_IDLE, owner<=0, rr_ptr<=NREQ-1 so requester 0 wins the first tie.
REQ-023 During and directly after reset: oreq.valid=0, grant=0, all iresps ready/last=0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst with no completion signalled upstream.

Structure
REQ-025 cbus_req_t, cbus_resp_t and mlen_t SHALL come from package common.
REQ-026 New typedef cbus_arb_state_t, an enum {ARB_IDLE, ARB_BUSY}, SHALL be added to package common.
REQ-027 The round-robin search SHALL be one combinational sub-module rr_picker (inputs: valid vector, rr_ptr; outputs: found, index).

Verification
REQ-028 Single read: ireqs[1] valid, addr=0x8000_0040, len=MLEN4 -> oreq.valid one cycle later, grant=2'b10, four oresp beats reach iresps[1] only, idle next cycle.
REQ-029 Tie after reset: both valid same cycle -> requester 0 granted first; after its last beat, one idle cycle, then requester 1 granted.
REQ-030 Fairness: both held valid for 6 bursts each of MLEN1 -> grants strictly alternate 0,1,0,1...
REQ-031 Lock: requester 0 in write burst MLEN8; requester 1 asserts at beat 3 -> oreq unchanged until beat 8 last; requester 1 granted two cycles after last.
REQ-032 Reset mid-burst: resetn low at beat 2 of MLEN4 read -> oreq.valid=0 and grant=0 immediately (asynchronous), state ARB_IDLE; after release, requester 0 wins tie.
REQ-033 Stray response: oresp.ready=1, last=1 in ARB_IDLE -> all iresps ready/last remain 0 and the state does not change.

Source files
------------

// File: rtl/common.sv
// Shared cache-bus types: request/response beats, burst length code and arbiter state.
// A burst carries len+1 beats; the responder flags its final beat with last.
package common;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    mlen_t       len;
    axi_burst_t  burst;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } cbus_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first valid index after rr_ptr, wrapping modulo N.
// Purely combinational; no flow control of its own.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW:0] cand;

  // Scan farthest-first so the closest valid candidate after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (valid[cand[IW-1:0]]) begin
        found = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter locking the shared cache bus to one requester per burst; grant is 1 cycle after request.
// Responses are forwarded combinationally to the owner only; a one-cycle idle bubble follows every release.
module cbus_arbiter
  import common::*;
#(
  parameter int NREQ = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NREQ],
  output cbus_resp_t       iresps [NREQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic [NREQ-1:0]  grant
);

  localparam int IW = $clog2(NREQ);

  cbus_arb_state_t state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NREQ-1:0] req_vld;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;

  always_comb begin
    req_vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_vld[i] = ireqs[i].valid;
    end
  end

  rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_picker (
    .valid  (req_vld),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .index  (pick_idx)
  );

  // rr_ptr resets to the top index so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= IW'(NREQ-1);
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_nxt = pick_idx;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Either the final beat or the owner abandoning the burst releases the bus.
        if ((oresp.ready && oresp.last) || !ireqs[owner].valid) begin
          state_nxt  = ARB_IDLE;
          rr_ptr_nxt = owner;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    oreq  = '0;
    grant = '0;
    if (state == ARB_BUSY) begin
      oreq         = ireqs[owner];
      grant[owner] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      iresps[i]       = '0;
      iresps[i].data  = oresp.data;
      iresps[i].ready = (state == ARB_BUSY) && (owner == IW'(i)) && oresp.ready;
      iresps[i].last  = (state == ARB_BUSY) && (owner == IW'(i)) && oresp.last;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed burst scenarios plus random traffic against a per-cycle arbitration model.
module tb_cbus_arbiter;
  import common::*;

  localparam int NREQ = 2;

  logic            clk = 1'b0;
  logic            resetn;
  cbus_req_t       ireqs  [NREQ];
  cbus_resp_t      iresps [NREQ];
  cbus_req_t       oreq;
  cbus_resp_t      oresp;
  logic [NREQ-1:0] grant;

  always #5 clk = ~clk;

  cbus_arbiter #(.NREQ(NREQ)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp),
    .grant  (grant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: is the bus owned, by whom, and who was served last.
  bit              m_busy;
  int              m_owner;
  int              m_last;
  int              beat;
  bit [NREQ-1:0]   done;
  logic [NREQ-1:0] prev_grant;
  int              grant_log[$];
  int              beats_seen[NREQ];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NREQ-1; beat = 0; done = '0; prev_grant = '0;
  endtask

  task automatic mk_req(input int i, input bit w, input logic [31:0] a, input mlen_t l);
    ireqs[i].valid    = 1'b1;
    ireqs[i].is_write = w;
    ireqs[i].addr     = a;
    ireqs[i].len      = l;
    ireqs[i].burst    = AXI_BURST_INCR;
    ireqs[i].strobe   = w ? 8'hff : 8'h00;
    ireqs[i].data     = {$urandom, $urandom};
  endtask

  task automatic rand_req(input int i);
    mlen_t l;
    case ($urandom_range(0, 3))
      0:       l = MLEN1;
      1:       l = MLEN2;
      2:       l = MLEN4;
      default: l = MLEN8;
    endcase
    mk_req(i, 1'($urandom_range(0, 1)), $urandom, l);
  endtask

  // Memory side: last accompanies the (len+1)-th accepted beat of the current burst.
  task automatic drive_resp(input bit rdy);
    oresp.ready = rdy;
    oresp.data  = {$urandom, $urandom};
    oresp.last  = rdy && m_busy && (beat == int'(ireqs[m_owner].len));
  endtask

  // Called just after inputs were driven at a falling edge; returns at the next falling edge.
  task automatic step();
    cbus_req_t       e_req;
    cbus_resp_t      e_rsp;
    logic [NREQ-1:0] e_grant;
    bit nb;
    int no, nl, nbeat;
    #1;
    e_req   = m_busy ? ireqs[m_owner] : '0;
    e_grant = '0;
    if (m_busy) e_grant[m_owner] = 1'b1;
    chk("oreq", 128'(oreq), 128'(e_req));
    chk("grant", 128'(grant), 128'(e_grant));
    for (int i = 0; i < NREQ; i++) begin
      e_rsp.data  = oresp.data;
      e_rsp.ready = m_busy && (m_owner == i) && oresp.ready;
      e_rsp.last  = m_busy && (m_owner == i) && oresp.last;
      chk($sformatf("iresp%0d", i), 128'(iresps[i]), 128'(e_rsp));
      if (iresps[i].ready) beats_seen[i]++;
    end
    if (grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < NREQ; i++) if (grant[i]) grant_log.push_back(i);
    end
    prev_grant = grant;

    done = '0; nb = m_busy; no = m_owner; nl = m_last;
    if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j = (m_last + k) % NREQ;
        if (!nb && ireqs[j].valid) begin nb = 1; no = j; end
      end
    end else if (oresp.ready && oresp.last) begin
      nb = 0; nl = m_owner; done[m_owner] = 1'b1;
    end else if (!ireqs[m_owner].valid) begin
      nb = 0; nl = m_owner;
    end
    if (e_req.valid && oresp.ready) nbeat = oresp.last ? 0 : beat + 1;
    else if (!e_req.valid)          nbeat = 0;
    else                            nbeat = beat;

    @(posedge clk);
    m_busy = nb; m_owner = no; m_last = nl; beat = nbeat;
    @(negedge clk);
  endtask

  task automatic run_burst(input int i, input bit rnd_rdy);
    int guard = 0;
    do begin
      drive_resp(rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      step();
      guard++;
    end while (!done[i] && guard < 100);
    chk($sformatf("burst_done%0d", i), 128'(done[i]), 128'(1));
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NREQ; i++) ireqs[i] = '0;
    oresp = '0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int ndone, guard;
    clear_inputs();
    model_reset();
    resetn = 1'b0;
    @(negedge clk);
    step();
    step();
    resetn = 1'b1;

    // Stray response while idle must be dropped.
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 64'hdead_beef_0000_0001;
    step();
    oresp = '0;
    step();
    chk("stray_grant", 128'(grant), 128'(0));

    // Single four-beat read from requester 1.
    for (int i = 0; i < NREQ; i++) beats_seen[i] = 0;
    mk_req(1, 1'b0, 32'h8000_0040, MLEN4);
    drive_resp(1'b0);
    step();
    chk("t1_grant", 128'(grant), 128'(2'b10));
    run_burst(1, 1'b0);
    ireqs[1].valid = 1'b0;
    drive_resp(1'b0);
    step();
    chk("t1_beats1", 128'(beats_seen[1]), 128'(4));
    chk("t1_beats0", 128'(beats_seen[0]), 128'(0));

    // Tie straight after reset: 0 first, then 1 after the bubble.
    clear_inputs();
    apply_reset();
    grant_log.delete();
    mk_req(0, 1'b0, 32'h1000_0000, MLEN2);
    mk_req(1, 1'b1, 32'h2000_0000, MLEN2);
    run_burst(0, 1'b0);
    ireqs[0].valid = 1'b0;
    run_burst(1, 1'b0);
    ireqs[1].valid = 1'b0;
    chk("tie_n", 128'(grant_log.size()), 128'(2));
    if (grant_log.size() >= 2) begin
      chk("tie_first", 128'(grant_log[0]), 128'(0));
      chk("tie_second", 128'(grant_log[1]), 128'(1));
    end

    // Fairness: both always requesting single-beat bursts.
    grant_log.delete();
    mk_req(0, 1'b0, $urandom, MLEN1);
    mk_req(1, 1'b1, $urandom, MLEN1);
    ndone = 0; guard = 0;
    while (ndone < 12 && guard < 200) begin
      drive_resp(1'b1);
      step();
      guard++;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin ndone++; mk_req(i, 1'(i), $urandom, MLEN1); end
      end
    end
    chk("fair_n", 128'(ndone), 128'(12));
    clear_inputs();
    step();
    for (int k = 0; k < 12; k++) begin
      if (k < grant_log.size()) chk($sformatf("fair_%0d", k), 128'(grant_log[k]), 128'(k % 2));
    end

    // Lock: requester 1 arrives mid-burst and waits for the eight-beat write to finish.
    mk_req(0, 1'b1, 32'h3000_0000, MLEN8);
    guard = 0;
    do begin
      if (m_busy && beat == 2 && !ireqs[1].valid) mk_req(1, 1'b0, 32'h4000_0000, MLEN2);
      drive_resp(1'b1);
      step();
      guard++;
    end while (!done[0] && guard < 100);
    chk("lock_done", 128'(done[0]), 128'(1));
    ireqs[0].valid = 1'b0;
    drive_resp(1'b0);
    step();
    chk("lock_grant1", 128'(grant), 128'(2'b10));
    run_burst(1, 1'b0);
    clear_inputs();
    step();

    // Asynchronous reset in the middle of a burst.
    mk_req(0, 1'b0, 32'h5000_0000, MLEN4);
    mk_req(1, 1'b0, 32'h6000_0000, MLEN4);
    drive_resp(1'b0);
    step();
    drive_resp(1'b1);
    step();
    drive_resp(1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_oreq_vld", 128'(oreq.valid), 128'(0));
    chk("arst_grant", 128'(grant), 128'(0));
    chk("arst_iresp0_rdy", 128'(iresps[0].ready), 128'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    grant_log.delete();
    drive_resp(1'b0);
    step();
    chk("arst_tie", 128'(grant), 128'(2'b01));
    run_burst(0, 1'b1);
    ireqs[0].valid = 1'b0;
    run_burst(1, 1'b1);
    clear_inputs();
    step();

    // Random traffic, including abandoned bursts and stray responses.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) begin
          if ($urandom_range(0, 1) != 0) rand_req(i);
          else ireqs[i].valid = 1'b0;
        end else if (!ireqs[i].valid) begin
          if ($urandom_range(0, 3) == 0) rand_req(i);
        end else if ($urandom_range(0, 39) == 0) begin
          ireqs[i].valid = 1'b0;
        end
      end
      drive_resp($urandom_range(0, 3) != 0);
      if (!m_busy && $urandom_range(0, 7) == 0) begin
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
